// File: rtl/debounce_pkg.sv
// Shared defaults and width helpers for the button debouncer family.
// No logic, no latency; no backpressure (constants only).
// Long-press support is selected by MULTI_BUTTON_DEBOUNCER_LONG_PRESS_EN in the modules.
package debounce_pkg;

  localparam int unsigned TICK_DIV_DEF   = 250000;
  localparam int unsigned STABLE_CNT_DEF = 4;
  localparam int unsigned HOLD_TICKS_DEF = 400;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DIV_W  = width_of(TICK_DIV_DEF);
  localparam int unsigned STAB_W = width_of(STABLE_CNT_DEF + 1);
  localparam int unsigned HOLD_W = width_of(HOLD_TICKS_DEF + 1);

endpackage

// File: rtl/debounce_channel.sv
// One debounced button: stability counter, level, press/release pulses, optional long-press.
// Latency: level and pulse register on the qualifying tick edge; no backpressure (pulses are fire-and-forget).
// Long-press hold counter present only with MULTI_BUTTON_DEBOUNCER_LONG_PRESS_EN.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CNT = STABLE_CNT_DEF,
  parameter int unsigned HOLD_TICKS = HOLD_TICKS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic s2,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int unsigned SW = width_of(STABLE_CNT + 1);

  logic [SW-1:0] stab_cnt;
  logic          flip;

  // The sample has differed for STABLE_CNT consecutive ticks including this one.
  assign flip = tick && (s2 != level) && (stab_cnt == SW'(STABLE_CNT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      stab_cnt      <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= flip & s2;
      release_pulse <= flip & ~s2;
      if (flip) begin
        level    <= s2;
        stab_cnt <= '0;
      end else if (tick) begin
        if (s2 != level) stab_cnt <= stab_cnt + SW'(1);
        else             stab_cnt <= '0;
      end
    end
  end

`ifdef MULTI_BUTTON_DEBOUNCER_LONG_PRESS_EN
  localparam int unsigned HW = width_of(HOLD_TICKS + 1);

  logic [HW-1:0] hold_cnt;

  // Saturating at HOLD_TICKS makes the long pulse one-shot until the next level change.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt   <= '0;
      long_pulse <= 1'b0;
    end else begin
      long_pulse <= tick && level && (hold_cnt == HW'(HOLD_TICKS - 1));
      if (flip) begin
        hold_cnt <= '0;
      end else if (tick && level && (hold_cnt != HW'(HOLD_TICKS))) begin
        hold_cnt <= hold_cnt + HW'(1);
      end
    end
  end
`else
  // HOLD_TICKS only shapes the long-press build; here the output is tied low.
  localparam logic HOLD_CFG_OK = (HOLD_TICKS >= 1);
  assign long_pulse = 1'b0 && HOLD_CFG_OK;
`endif

endmodule

// File: rtl/multi_button_debouncer.sv
// N-channel pushbutton debouncer: 2-flop sync, shared sample-tick divider, per-channel qualifier.
// Latency 2+(STABLE_CNT-1)*TICK_DIV+1 .. 2+STABLE_CNT*TICK_DIV clk; no backpressure.
// Optional long-press pulse with MULTI_BUTTON_DEBOUNCER_LONG_PRESS_EN; port list identical in both builds.
module multi_button_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned N_BTN      = 4,
  parameter int unsigned TICK_DIV   = TICK_DIV_DEF,
  parameter int unsigned STABLE_CNT = STABLE_CNT_DEF,
  parameter int unsigned HOLD_TICKS = HOLD_TICKS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_pulse
);

  localparam int unsigned DW = width_of(TICK_DIV);

  logic [DW-1:0]    div_cnt;
  logic             tick;
  logic [N_BTN-1:0] sync_s1;
  logic [N_BTN-1:0] sync_s2;

  assign tick = (div_cnt == DW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_s1 <= '0;
      sync_s2 <= '0;
    end else begin
      sync_s1 <= btn_in;
      sync_s2 <= sync_s1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CNT (STABLE_CNT),
      .HOLD_TICKS (HOLD_TICKS)
    ) u_channel (
      .clk           (clk),
      .rst           (rst),
      .tick          (tick),
      .s2            (sync_s2[i]),
      .level         (btn_level[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .long_pulse    (long_pulse[i])
    );
  end

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Bench for multi_button_debouncer: directed scenarios plus random bouncing against a behavioural model.
// Long-press expectations follow MULTI_BUTTON_DEBOUNCER_LONG_PRESS_EN.
module tb_multi_button_debouncer;

  localparam int NB = 2;
  localparam int TD = 4;
  localparam int SC = 3;
  localparam int HT = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn_in = '0;
  logic [NB-1:0] btn_level, press_pulse, release_pulse, long_pulse;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multi_button_debouncer #(
    .N_BTN(NB), .TICK_DIV(TD), .STABLE_CNT(SC), .HOLD_TICKS(HT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_in        (btn_in),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse)
  );

  // ---------------- behavioural model ----------------
  // Level flips on a tick when the last SC tick samples (since reset) all differ from it.
  logic          rst_q = 1'b1;
  logic [NB-1:0] in_q = '0;
  always @(posedge clk) begin
    rst_q <= rst;
    in_q  <= btn_in;
  end

  int            m_n;
  logic [NB-1:0] m_q1, m_q2, m_lvl, m_press, m_rel, m_long;
  logic [SC-1:0] m_hist [NB];
  int            m_seen [NB];
  int            m_held [NB];

  task automatic model_step(input logic r, input logic [NB-1:0] d);
    logic [NB-1:0] s;
    bit tk;
    m_press = '0; m_rel = '0; m_long = '0;
    if (r) begin
      m_n = 0; m_q1 = '0; m_q2 = '0; m_lvl = '0;
      for (int c = 0; c < NB; c++) begin
        m_hist[c] = '0; m_seen[c] = 0; m_held[c] = 0;
      end
    end else begin
      m_n++;
      tk = ((m_n % TD) == 0);
      s = m_q2; m_q2 = m_q1; m_q1 = d;
      if (tk) begin
        for (int c = 0; c < NB; c++) begin
          m_hist[c] = {m_hist[c][SC-2:0], s[c]};
          m_seen[c]++;
          if (m_lvl[c]) begin
            m_held[c]++;
`ifdef MULTI_BUTTON_DEBOUNCER_LONG_PRESS_EN
            m_long[c] = (m_held[c] == HT);
`endif
          end
          if (m_seen[c] >= SC && m_hist[c] == {SC{~m_lvl[c]}}) begin
            m_lvl[c]   = s[c];
            m_press[c] = s[c];
            m_rel[c]   = ~s[c];
            m_held[c]  = 0;
          end
        end
      end
    end
  endtask

  task automatic cmp(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s at %0t: got %b, expected %b", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    model_step(rst_q, in_q);
    cmp("model_level",   btn_level,     m_lvl);
    cmp("model_press",   press_pulse,   m_press);
    cmp("model_release", release_pulse, m_rel);
    cmp("model_long",    long_pulse,    m_long);
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    vectors++;
    if (act < lo || act > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // kind: 0 press, 1 release, 2 long. lat = -1 when the bound expires.
  task automatic wait_pulse(input int ch, input int kind, input int maxc, output int lat);
    logic hit;
    lat = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      hit = (kind == 0) ? press_pulse[ch] : (kind == 1) ? release_pulse[ch] : long_pulse[ch];
      if (hit) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic count_win(input int cycles, output int np, output int nr, output int nl);
    np = 0; nr = 0; nl = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      np += int'(press_pulse[0]);
      nr += int'(release_pulse[0]);
      nl += int'(long_pulse[0]);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, np, nr, nl;
    int rem [NB];

    // Reset with both buttons held; outputs must stay 0 throughout.
    rst = 1'b1; btn_in = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_outputs", int'({btn_level, press_pulse, release_pulse, long_pulse}), 0);
    end
    rst = 1'b0;
    wait_pulse(0, 0, 30, lat);
    chk_rng("reset_held_press_latency", lat, 11, 14);
    chk("reset_held_press_both", int'(press_pulse), 3);
    chk("reset_held_level", int'(btn_level), 3);

    btn_in = 2'b00;
    wait_pulse(0, 1, 30, lat);
    chk_rng("release_both_latency", lat, 11, 14);
    chk("release_both_pulse", int'(release_pulse), 3);
    repeat (5) @(negedge clk);

    // Clean press on channel 0 only.
    btn_in = 2'b01;
    wait_pulse(0, 0, 30, lat);
    chk_rng("clean_press_latency", lat, 11, 14);
    chk("clean_press_pulse", int'(press_pulse), 1);
    chk("clean_press_level", int'(btn_level), 1);
    count_win(30, np, nr, nl);
    chk("clean_press_no_repeat", np, 0);
    btn_in = 2'b00;
    wait_pulse(0, 1, 30, lat);
    chk_rng("clean_release_latency", lat, 11, 14);
    repeat (5) @(negedge clk);

    // Short glitch rejected.
    btn_in = 2'b01;
    repeat (6) @(negedge clk);
    btn_in = 2'b00;
    count_win(30, np, nr, nl);
    chk("glitch_no_press", np, 0);
    chk("glitch_level", int'(btn_level[0]), 0);

    // Bounce 1,0,1 then steady high gives exactly one press.
    btn_in = 2'b01; repeat (2) @(negedge clk);
    btn_in = 2'b00; repeat (2) @(negedge clk);
    btn_in = 2'b01;
    count_win(40, np, nr, nl);
    chk("bounce_one_press", np, 1);
    chk("bounce_level", int'(btn_level[0]), 1);

    // Release from a high level.
    btn_in = 2'b00;
    wait_pulse(0, 1, 30, lat);
    chk_rng("release_latency", lat, 11, 14);
    count_win(20, np, nr, nl);
    chk("release_no_press", np, 0);
    chk("release_single", nr, 0);

    // Reset 8 cycles into qualification, then full requalification.
    btn_in = 2'b01;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_level", int'(btn_level[0]), 0);
    wait_pulse(0, 0, 30, lat);
    chk_rng("midreset_requal_latency", lat, 11, 14);

    // Long press while held.
    wait_pulse(0, 2, 40, lat);
`ifdef MULTI_BUTTON_DEBOUNCER_LONG_PRESS_EN
    chk_rng("long_latency", lat, 16, 24);
`else
    chk("long_absent", lat, -1);
`endif
    count_win(60, np, nr, nl);
    chk("long_no_repeat", nl, 0);

    // Random bouncing on both channels with occasional reset.
    for (int c = 0; c < NB; c++) rem[c] = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 499) == 0);
      for (int c = 0; c < NB; c++) begin
        if (rem[c] == 0) begin
          btn_in[c] = 1'($urandom_range(0, 1));
          rem[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                                 : int'($urandom_range(1, 12));
        end else begin
          rem[c]--;
        end
      end
    end
    rst = 1'b0;
    btn_in = '0;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
